// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect types: write response codes and master-count limit.
package axi_ic_pkg;
  localparam int MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;
endpackage

// File: rtl/wr_resp_fifo.sv
// Per-master response FIFO: registered storage, head visible the cycle after a push.
// Pushes while full and pops while empty are ignored; the caller gates push with full.
module wr_resp_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps DEPTH=1 and any power of two on the same path.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/write_resp_router.sv
// Routes write responses by ID into per-master FIFOs; one-cycle latency to m_bvalid.
// in_ready drops only for a full target FIFO; bad IDs are always consumed and counted.
module write_resp_router
  import axi_ic_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ID_W        = $clog2(NUM_MASTERS),
  parameter int DEPTH       = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [ID_W-1:0]          in_id,
  input  logic [1:0]               in_bresp,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [2*NUM_MASTERS-1:0] m_bresp,
  output logic [NUM_MASTERS-1:0]   m_bvalid,
  input  logic [NUM_MASTERS-1:0]   m_bready,
  input  logic                     clear_err,
  output logic                     bad_id_err,
  output logic [ERR_CNT_W-1:0]     bad_id_cnt,
  output logic [NUM_MASTERS-1:0]   buf_full
);
  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_cfg
    $error("write_resp_router: NUM_MASTERS out of range");
  end

  localparam logic [ID_W:0] NM_ID = NUM_MASTERS[ID_W:0];

  resp_t                  in_resp;
  logic                   id_ok;
  logic                   sel_full;
  logic                   accept;
  logic                   bad_acc;
  logic [NUM_MASTERS-1:0] fifo_full;
  logic [NUM_MASTERS-1:0] fifo_empty;
  logic [1:0]             fifo_dout [NUM_MASTERS];

  assign in_resp = resp_t'(in_bresp);
  assign id_ok   = ({1'b0, in_id} < NM_ID);

  always_comb begin
    sel_full = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (in_id == ID_W'(i)) sel_full = fifo_full[i];
    end
  end

  // Ready is a function of FIFO state only, never of m_bready.
  assign in_ready = !ARESET && (!id_ok || !sel_full);
  assign accept   = in_valid && in_ready;
  assign bad_acc  = accept && !id_ok;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_master
    wr_resp_fifo #(
      .WIDTH($bits(resp_t)),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk  (ACLK),
      .rst  (ARESET),
      .push (accept && id_ok && (in_id == ID_W'(g))),
      .pop  (m_bready[g]),
      .din  (in_resp),
      .full (fifo_full[g]),
      .empty(fifo_empty[g]),
      .dout (fifo_dout[g])
    );

    assign m_bvalid[g]       = !fifo_empty[g];
    assign m_bresp[2*g +: 2] = fifo_empty[g] ? 2'b00 : fifo_dout[g];
    assign buf_full[g]       = fifo_full[g];
  end

  // A bad-ID event in the same cycle as clear_err wins and restarts the count at 1.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      bad_id_err <= 1'b0;
      bad_id_cnt <= '0;
    end else if (bad_acc) begin
      bad_id_err <= 1'b1;
      if (clear_err)        bad_id_cnt <= ERR_CNT_W'(1);
      else if (!(&bad_id_cnt)) bad_id_cnt <= bad_id_cnt + 1'b1;
    end else if (clear_err) begin
      bad_id_err <= 1'b0;
      bad_id_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_write_resp_router.sv
// Bench for write_resp_router: queue model per master checked every cycle, plus directed literals.
module tb_write_resp_router;
  import axi_ic_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  // Instance A: 4 masters, depth 2, 8-bit counter
  logic [1:0] a_id, a_bresp;
  logic       a_valid, a_ready, a_clr, a_err;
  logic [7:0] a_m_bresp, a_cnt;
  logic [3:0] a_m_bvalid, a_m_bready, a_full;

  // Instance B: 3 masters, depth 4, 2-bit counter
  logic [1:0] b_id, b_bresp, b_cnt;
  logic       b_valid, b_ready, b_clr, b_err;
  logic [5:0] b_m_bresp;
  logic [2:0] b_m_bvalid, b_m_bready, b_full;

  write_resp_router #(.NUM_MASTERS(4), .DEPTH(2), .ERR_CNT_W(8)) u_a (
    .ACLK(clk), .ARESET(rst), .in_id(a_id), .in_bresp(a_bresp), .in_valid(a_valid),
    .in_ready(a_ready), .m_bresp(a_m_bresp), .m_bvalid(a_m_bvalid), .m_bready(a_m_bready),
    .clear_err(a_clr), .bad_id_err(a_err), .bad_id_cnt(a_cnt), .buf_full(a_full)
  );

  write_resp_router #(.NUM_MASTERS(3), .DEPTH(4), .ERR_CNT_W(2)) u_b (
    .ACLK(clk), .ARESET(rst), .in_id(b_id), .in_bresp(b_bresp), .in_valid(b_valid),
    .in_ready(b_ready), .m_bresp(b_m_bresp), .m_bvalid(b_m_bvalid), .m_bready(b_m_bready),
    .clear_err(b_clr), .bad_id_err(b_err), .bad_id_cnt(b_cnt), .buf_full(b_full)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: plain queues per master plus error status.
  logic [1:0] qa [4][$];
  logic [1:0] qb [3][$];
  logic       me_b;
  int         mc_b;
  logic       acc_a, acc_b, bad_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) qa[i].delete();
      for (int i = 0; i < 3; i++) qb[i].delete();
      me_b = 1'b0;
      mc_b = 0;
    end else begin
      acc_a = a_valid && (qa[a_id].size() < 2);
      for (int i = 0; i < 4; i++)
        if (a_m_bready[i] && qa[i].size() > 0) void'(qa[i].pop_front());
      if (acc_a) qa[a_id].push_back(a_bresp);

      bad_b = (b_id >= 2'd3);
      acc_b = b_valid && (bad_b || qb[b_id].size() < 4);
      for (int i = 0; i < 3; i++)
        if (b_m_bready[i] && qb[i].size() > 0) void'(qb[i].pop_front());
      if (acc_b && !bad_b) qb[b_id].push_back(b_bresp);
      if (acc_b && bad_b) begin
        me_b = 1'b1;
        mc_b = b_clr ? 1 : ((mc_b == 3) ? 3 : mc_b + 1);
      end else if (b_clr) begin
        me_b = 1'b0;
        mc_b = 0;
      end
    end
  end

  logic [3:0] ev_a, ef_a;
  logic [7:0] er_a;
  logic [2:0] ev_b, ef_b;
  logic [5:0] er_b;
  logic       erdy_a, erdy_b;
  logic [1:0] deliv1 [$];
  logic [1:0] delivb [$];

  always @(negedge clk) begin
    ev_a = '0; ef_a = '0; er_a = '0;
    for (int i = 0; i < 4; i++) begin
      ev_a[i] = (qa[i].size() != 0);
      ef_a[i] = (qa[i].size() == 2);
      if (ev_a[i]) er_a[2*i +: 2] = qa[i][0];
    end
    erdy_a = !rst && (qa[a_id].size() < 2);
    ev_b = '0; ef_b = '0; er_b = '0;
    for (int i = 0; i < 3; i++) begin
      ev_b[i] = (qb[i].size() != 0);
      ef_b[i] = (qb[i].size() == 4);
      if (ev_b[i]) er_b[2*i +: 2] = qb[i][0];
    end
    if (b_id >= 2'd3) erdy_b = !rst;
    else              erdy_b = !rst && (qb[b_id].size() < 4);

    chk("a_m_bvalid", 32'(a_m_bvalid), 32'(ev_a));
    chk("a_m_bresp",  32'(a_m_bresp),  32'(er_a));
    chk("a_buf_full", 32'(a_full),     32'(ef_a));
    chk("a_in_ready", 32'(a_ready),    32'(erdy_a));
    chk("a_bad_err",  32'(a_err),      32'(0));
    chk("a_bad_cnt",  32'(a_cnt),      32'(0));
    chk("b_m_bvalid", 32'(b_m_bvalid), 32'(ev_b));
    chk("b_m_bresp",  32'(b_m_bresp),  32'(er_b));
    chk("b_buf_full", 32'(b_full),     32'(ef_b));
    chk("b_in_ready", 32'(b_ready),    32'(erdy_b));
    chk("b_bad_err",  32'(b_err),      32'(me_b));
    chk("b_bad_cnt",  32'(b_cnt),      32'(mc_b));

    if (!rst && a_m_bvalid[1] && a_m_bready[1]) deliv1.push_back(a_m_bresp[3:2]);
    if (!rst && b_m_bvalid[0] && b_m_bready[0]) delivb.push_back(b_m_bresp[1:0]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  logic [1:0] exp1 [3];
  logic [1:0] seq [20];
  int         sent, cyc;
  logic       acc;

  initial begin
    a_id = '0; a_bresp = '0; a_valid = 1'b0; a_clr = 1'b0; a_m_bready = '0;
    b_id = '0; b_bresp = '0; b_valid = 1'b0; b_clr = 1'b0; b_m_bready = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_ready",  32'(a_ready),    32'(0));
    chk("rst_a_bvalid", 32'(a_m_bvalid), 32'(0));
    chk("rst_b_cnt",    32'(b_cnt),      32'(0));
    rst = 1'b0;
    #1 chk("post_rst_a_ready", 32'(a_ready), 32'(1));
    a_m_bready = 4'hF;
    b_m_bready = 3'b111;
    step();

    // Single response to master 2 appears after one edge
    a_valid = 1'b1; a_id = 2'd2; a_bresp = OKAY;
    #1 chk("single_ready", 32'(a_ready), 32'(1));
    step();
    a_valid = 1'b0;
    chk("single_bvalid", 32'(a_m_bvalid), 32'(4'b0100));
    chk("single_bresp2", 32'(a_m_bresp[5:4]), 32'(0));
    step();
    chk("single_drained", 32'(a_m_bvalid), 32'(0));

    // Backpressure on master 1
    a_m_bready = 4'b1101;
    a_valid = 1'b1; a_id = 2'd1; a_bresp = SLVERR;
    step();
    a_bresp = OKAY;
    step();
    a_bresp = DECERR;
    #1;
    chk("bp_ready_full", 32'(a_ready), 32'(0));
    chk("bp_buf_full",   32'(a_full),  32'(4'b0010));
    chk("bp_head",       32'(a_m_bresp[3:2]), 32'(2));
    step();
    chk("bp_still_full", 32'(a_full[1]), 32'(1));

    // Master 3 flows while master 1 is stalled
    a_id = 2'd3; a_bresp = EXOKAY;
    #1 chk("indep_ready", 32'(a_ready), 32'(1));
    step();
    a_valid = 1'b0;
    chk("indep_bvalid", 32'(a_m_bvalid), 32'(4'b1010));
    chk("indep_bresp3", 32'(a_m_bresp[7:6]), 32'(1));

    // Release master 1 and retry the refused DECERR
    a_m_bready = 4'hF;
    a_valid = 1'b1; a_id = 2'd1; a_bresp = DECERR;
    #1 chk("bp_retry_blocked", 32'(a_ready), 32'(0));
    step();
    chk("bp_retry_ready", 32'(a_ready), 32'(1));
    step();
    a_valid = 1'b0;
    repeat (3) step();
    exp1[0] = 2'd2; exp1[1] = 2'd0; exp1[2] = 2'd3;
    chk("bp_deliv_count", 32'(deliv1.size()), 32'(3));
    for (int k = 0; k < 3; k++)
      chk("bp_deliv_order", (k < deliv1.size()) ? 32'(deliv1[k]) : 32'hFFFF, 32'(exp1[k]));

    // Reset pulse with two entries buffered at master 0
    a_m_bready = 4'b1110;
    a_valid = 1'b1; a_id = 2'd0; a_bresp = EXOKAY;
    step();
    a_bresp = SLVERR;
    step();
    a_valid = 1'b0; a_id = 2'd2;
    chk("rstmid_pre_bvalid", 32'(a_m_bvalid), 32'(4'b0001));
    chk("rstmid_pre_full",   32'(a_full),     32'(4'b0001));
    #2 rst = 1'b1;
    #1;
    chk("rstmid_bvalid", 32'(a_m_bvalid), 32'(0));
    chk("rstmid_ready",  32'(a_ready),    32'(0));
    chk("rstmid_full",   32'(a_full),     32'(0));
    #2 rst = 1'b0;
    a_m_bready = 4'hF;
    repeat (3) step();
    chk("rstmid_no_stale", 32'(a_m_bvalid), 32'(0));

    // Bad IDs on the 3-master instance
    b_valid = 1'b1; b_id = 2'd3; b_bresp = SLVERR;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bad_ready", 32'(b_ready), 32'(1));
      step();
    end
    b_valid = 1'b0;
    chk("bad_no_bvalid", 32'(b_m_bvalid), 32'(0));
    chk("bad_err",       32'(b_err),      32'(1));
    chk("bad_cnt_sat",   32'(b_cnt),      32'(3));
    b_clr = 1'b1; b_valid = 1'b1;
    step();
    b_clr = 1'b0; b_valid = 1'b0;
    chk("bad_clr_race_cnt", 32'(b_cnt), 32'(1));
    chk("bad_clr_race_err", 32'(b_err), 32'(1));
    b_clr = 1'b1;
    step();
    b_clr = 1'b0;
    chk("bad_clr_cnt", 32'(b_cnt), 32'(0));
    chk("bad_clr_err", 32'(b_err), 32'(0));

    // Stream 20 responses to master 0 through depth-4 FIFO with random drain
    for (int k = 0; k < 20; k++) seq[k] = 2'(k);
    sent = 0; cyc = 0;
    b_id = 2'd0;
    while (sent < 20 && cyc < 500) begin
      b_m_bready = {2'b11, 1'($urandom_range(0, 1))};
      b_valid = 1'b1;
      b_bresp = seq[sent];
      #1 acc = b_ready;
      step();
      if (acc) sent++;
      cyc++;
    end
    b_valid = 1'b0;
    b_m_bready = 3'b111;
    repeat (8) step();
    chk("wrap_sent",  32'(sent), 32'(20));
    chk("wrap_count", 32'(delivb.size()), 32'(20));
    for (int k = 0; k < 20; k++)
      chk("wrap_order", (k < delivb.size()) ? 32'(delivb[k]) : 32'hFFFF, 32'(seq[k]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/write_resp_router.md
WRITE_RESP_ROUTER -- requirements
Module: write_resp_router

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, meaning number of master-side response ports (legal 2..8).
REQ-002 SHALL have parameter ID_W, default $clog2(NUM_MASTERS), meaning width of the routing ID.
REQ-003 SHALL have parameter DEPTH, default 2, meaning per-master response buffer entries (power of two, 1..16).
REQ-004 SHALL have parameter ERR_CNT_W, default 8, meaning width of the bad-ID event counter.
REQ-005 SHALL have one clock and asynchronous active-high reset: ACLK input 1 (rising-edge clock); ARESET input 1 (async active-high reset).
REQ-006 SHALL have ports: in_id input ID_W (target master index); in_bresp input 2 (write response code); in_valid input 1; in_ready output 1.
REQ-007 SHALL have ports: m_bresp output 2*NUM_MASTERS (master i at bits [2i+1:2i]); m_bvalid output NUM_MASTERS; m_bready input NUM_MASTERS.
REQ-008 SHALL have ports: clear_err input 1 (clears error status); bad_id_err output 1 (sticky flag); bad_id_cnt output ERR_CNT_W (saturating count); buf_full output NUM_MASTERS (per-master full status).

Function
REQ-009 SHALL accept a response on the rising ACLK edge where in_valid && in_ready.
REQ-010 SHALL drive in_ready = 1 when in_id >= NUM_MASTERS, else = !buf_full[in_id]; in_ready SHALL NOT depend combinationally on m_bready.
REQ-011 SHALL push an accepted response with in_id < NUM_MASTERS into the FIFO of master in_id, in order.
REQ-012 SHALL drive m_bvalid[i] = (FIFO i non-empty) and m_bresp[i] = FIFO i head; there is no empty-FIFO bypass.
REQ-013 SHALL have a latency of 1 cycle: a response accepted at edge k is visible on m_bvalid/m_bresp from edge k.
REQ-014 SHALL pop FIFO i on an edge where m_bvalid[i] && m_bready[i].
REQ-015 SHALL keep m_bresp[i] stable while m_bvalid[i] && !m_bready[i].
REQ-016 SHALL leave FIFO occupancy unchanged on a simultaneous push and pop of a non-full, non-empty FIFO.
REQ-017 SHALL refuse a push to a full FIFO via in_ready=0, even when a pop occurs that cycle.
REQ-018 SHALL handle pointer wrap-around modulo DEPTH.
REQ-019 SHALL drive buf_full[i] = (occupancy == DEPTH).
REQ-020 SHALL consume and drop an accepted response with in_id >= NUM_MASTERS, with no m_bvalid asserted, set bad_id_err, and increment bad_id_cnt, saturating at all-ones.
REQ-021 SHALL, on clear_err=1, clear bad_id_err to 0 and bad_id_cnt to 0.
REQ-022 SHALL, on clear_err coinciding with a bad-ID accept, give the new event priority: err=1, cnt=1.
REQ-023 SHALL operate FIFOs of different masters fully independently; one master's backpressure SHALL NOT stall another master's traffic.

Reset
REQ-024 SHALL, while ARESET=1, asynchronously empty all FIFOs and force m_bvalid=0, m_bresp=0, buf_full=0, bad_id_err=0, bad_id_cnt=0, and in_ready=0.
REQ-025 SHALL discard buffered responses when reset asserts mid-operation, and SHALL NOT deliver them after reset releases.
REQ-026 SHALL have in_ready follow REQ-010 from the first edge after ARESET deasserts.

Structure
REQ-027 SHALL take the following from shared package axi_ic_pkg: resp_t enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) and the max-master constant.
REQ-028 SHALL implement each per-master buffer as one instance of sub-module wr_resp_fifo (params WIDTH, DEPTH; push, pop, full, empty, dout), generated NUM_MASTERS times.
REQ-029 SHALL keep routing decode, in_ready mux, and the error counter in the top module.

Verification
REQ-030 SHALL verify in-order delivery: with NUM_MASTERS=4, DEPTH=2, m_bready=1111, send id=2 resp=OKAY at edge 1 -> m_bvalid=0100 and m_bresp[2]=0 from edge 1; other masters remain idle.
REQ-031 SHALL verify backpressure: with m_bready[1]=0, send 3 responses to id=1 (SLVERR, OKAY, DECERR) -> first two accepted, buf_full[1]=1, in_ready=0 on the third; after raising m_bready, delivery order is 2,0,3.
REQ-032 SHALL verify independence: with master 1 full and stalled, send id=3 EXOKAY -> accepted immediately, and m_bvalid[3]=1 next edge.
REQ-033 SHALL verify bad-ID handling: with NUM_MASTERS=3 and ERR_CNT_W=2, send id=3 five times -> all accepted, no m_bvalid, bad_id_err=1, bad_id_cnt=3 (saturated); clear_err plus a bad ID in the same cycle -> cnt=1.
REQ-034 SHALL verify reset mid-operation: with two entries buffered at master 0, pulse ARESET mid-cycle -> m_bvalid=0 and in_ready=0 immediately; after release, no stale response appears.
REQ-035 SHALL verify wrap-around: with DEPTH=4 and m_bready toggled randomly, stream 20 responses to id=0 -> all 20 delivered in order, with no loss or duplication.
